// File: rtl/registro_carga_sync.sv
// Input-capture holding register with a valid/ready handshake and sticky overrun,
// plus per-button synchronisers that emit one-cycle rising-edge pulses.
module registro_carga_sync #(
  parameter int unsigned N           = 4,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned BTN_W       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      Z_in,
  input  logic [N-1:0]      Y_in,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              cap_en,
  input  logic [BTN_W-1:0]  btn_in,
  input  logic              ready_in,
  output logic [N-1:0]      Z_m,
  output logic [N-1:0]      Y_m,
  output logic [MODE_W-1:0] mode_m,
  output logic              valid_m,
  output logic [BTN_W-1:0]  btn_change_m,
  output logic              overrun
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                load_c;
  logic                drop_c;
  logic [N-1:0]        z_q;
  logic [N-1:0]        y_q;
  logic [MODE_W-1:0]   mode_q;
  logic                overrun_q;

  logic [SYNC_STAGES-1:0][BTN_W-1:0] sync_q;
  logic [BTN_W-1:0]                  hist_q;
  logic [BTN_W-1:0]                  pulse_q;

  // Handshake next-state: decide whether to load, release, or drop a capture.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_en) begin
          load_c  = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ready_in) begin
          if (cap_en) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (cap_en) begin
          drop_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register; data is kept after a transfer, only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      z_q       <= '0;
      y_q       <= '0;
      mode_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        z_q    <= Z_in;
        y_q    <= Y_in;
        mode_q <= mode_in;
      end
      if (drop_c) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Button synchronisers; stage 0 is the flop nearest the pad.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      hist_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign Z_m          = z_q;
  assign Y_m          = y_q;
  assign mode_m       = mode_q;
  assign valid_m      = (state_q == FULL);
  assign btn_change_m = pulse_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_registro_carga_sync.sv
// Self-checking bench for registro_carga_sync: per-cycle behavioural model plus directed literals.
module tb_registro_carga_sync;

  localparam int unsigned N      = 4;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned BTN_W  = 2;
  localparam int unsigned S      = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      Z_in, Y_in;
  logic [MODE_W-1:0] mode_in;
  logic              cap_en;
  logic [BTN_W-1:0]  btn_in;
  logic              ready_in;
  logic [N-1:0]      Z_m, Y_m;
  logic [MODE_W-1:0] mode_m;
  logic              valid_m;
  logic [BTN_W-1:0]  btn_change_m;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  registro_carga_sync #(
    .N(N), .MODE_W(MODE_W), .BTN_W(BTN_W), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .Z_in(Z_in), .Y_in(Y_in), .mode_in(mode_in),
    .cap_en(cap_en), .btn_in(btn_in), .ready_in(ready_in),
    .Z_m(Z_m), .Y_m(Y_m), .mode_m(mode_m), .valid_m(valid_m),
    .btn_change_m(btn_change_m), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: held data/valid/overrun from the handshake rules; pulse after edge k is
  // b(k-S) & ~b(k-S-1) where b(j) is btn_in sampled at edge j (zero at/before reset).
  logic [N-1:0]      ez, ey;
  logic [MODE_W-1:0] em;
  logic              ev, eo;
  logic [BTN_W-1:0]  ep;
  logic [BTN_W-1:0]  bq [0:S+1];

  initial begin
    ez = '0; ey = '0; em = '0; ev = 1'b0; eo = 1'b0; ep = '0;
    for (int i = 0; i <= S + 1; i++) bq[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      ez = '0; ey = '0; em = '0; ev = 1'b0; eo = 1'b0; ep = '0;
      for (int i = 0; i <= S + 1; i++) bq[i] = '0;
    end else begin
      if (!ev) begin
        if (cap_en) begin ez = Z_in; ey = Y_in; em = mode_in; ev = 1'b1; end
      end else if (ready_in) begin
        if (cap_en) begin ez = Z_in; ey = Y_in; em = mode_in; end
        else ev = 1'b0;
      end else if (cap_en) begin
        eo = 1'b1;
      end
      for (int i = S + 1; i > 0; i--) bq[i] = bq[i-1];
      bq[0] = btn_in;
      ep = bq[S] & ~bq[S+1];
    end
    #1;
    chk("model Z_m", 32'(Z_m), 32'(ez));
    chk("model Y_m", 32'(Y_m), 32'(ey));
    chk("model mode_m", 32'(mode_m), 32'(em));
    chk("model valid_m", 32'(valid_m), 32'(ev));
    chk("model overrun", 32'(overrun), 32'(eo));
    chk("model btn_change_m", 32'(btn_change_m), 32'(ep));
  end

  task automatic edge1();
    @(negedge clk);
  endtask

  // Compact table: {cap_en, ready_in, Z, Y, mode}
  typedef struct packed {
    logic              cap;
    logic              rdy;
    logic [N-1:0]      z;
    logic [N-1:0]      y;
    logic [MODE_W-1:0] m;
  } vec_t;
  vec_t tbl [0:9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'hF, 4'h0, 2'd3};
    tbl[1] = '{1'b0, 1'b0, 4'h1, 4'h1, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 4'h6, 4'hC, 2'd1};
    tbl[3] = '{1'b1, 1'b1, 4'h0, 4'hF, 2'd2};
    tbl[4] = '{1'b0, 1'b1, 4'h8, 4'h8, 2'd3};
    tbl[5] = '{1'b0, 1'b1, 4'h2, 4'h2, 2'd1};
    tbl[6] = '{1'b1, 1'b1, 4'hB, 4'h4, 2'd0};
    tbl[7] = '{1'b1, 1'b0, 4'hD, 4'h3, 2'd2};
    tbl[8] = '{1'b0, 1'b0, 4'hE, 4'h7, 2'd1};
    tbl[9] = '{1'b0, 1'b1, 4'h5, 4'h9, 2'd3};
  end

  initial begin
    // Reset with every input nonzero
    rst = 1'b0; Z_in = 4'hF; Y_in = 4'hF; mode_in = 2'd3;
    cap_en = 1'b1; btn_in = 2'b11; ready_in = 1'b1;
    repeat (2) edge1();
    chk("reset Z_m", 32'(Z_m), 32'h0);
    chk("reset Y_m", 32'(Y_m), 32'h0);
    chk("reset mode_m", 32'(mode_m), 32'h0);
    chk("reset valid_m", 32'(valid_m), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    chk("reset btn_change_m", 32'(btn_change_m), 32'h0);

    rst = 1'b1; cap_en = 1'b0; btn_in = 2'b00; ready_in = 1'b0;
    Z_in = 4'h0; Y_in = 4'h0; mode_in = 2'd0;
    edge1();
    chk("release valid_m", 32'(valid_m), 32'h0);
    chk("release Z_m", 32'(Z_m), 32'h0);

    // Basic capture
    Z_in = 4'hA; Y_in = 4'h5; mode_in = 2'b10; cap_en = 1'b1;
    edge1();
    cap_en = 1'b0;
    chk("cap Z_m", 32'(Z_m), 32'hA);
    chk("cap Y_m", 32'(Y_m), 32'h5);
    chk("cap mode_m", 32'(mode_m), 32'h2);
    chk("cap valid_m", 32'(valid_m), 32'h1);
    ready_in = 1'b1;
    edge1();
    ready_in = 1'b0;
    chk("xfer valid_m", 32'(valid_m), 32'h0);
    chk("xfer Z_m kept", 32'(Z_m), 32'hA);

    // Overrun
    Z_in = 4'h3; cap_en = 1'b1;
    edge1();
    chk("ovr first Z_m", 32'(Z_m), 32'h3);
    Z_in = 4'h7;
    edge1();
    cap_en = 1'b0;
    chk("ovr Z_m held", 32'(Z_m), 32'h3);
    chk("ovr flag", 32'(overrun), 32'h1);
    ready_in = 1'b1;
    edge1();
    ready_in = 1'b0;
    chk("ovr after xfer valid", 32'(valid_m), 32'h0);
    chk("ovr sticky", 32'(overrun), 32'h1);
    repeat (3) edge1();
    chk("ovr still sticky", 32'(overrun), 32'h1);
    rst = 1'b0;
    edge1();
    rst = 1'b1;
    chk("ovr cleared by reset", 32'(overrun), 32'h0);

    // Back-to-back
    Z_in = 4'h3; cap_en = 1'b1;
    edge1();
    chk("b2b first Z_m", 32'(Z_m), 32'h3);
    Z_in = 4'h9; ready_in = 1'b1;
    edge1();
    chk("b2b Z_m", 32'(Z_m), 32'h9);
    chk("b2b valid_m", 32'(valid_m), 32'h1);
    chk("b2b overrun", 32'(overrun), 32'h0);
    cap_en = 1'b0;
    edge1();
    ready_in = 1'b0;
    chk("b2b drain valid", 32'(valid_m), 32'h0);

    // Button 0 rise, held 10 cycles, pulse exactly at edge S+1
    btn_in = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      edge1();
      chk($sformatf("btn0 edge %0d", k), 32'(btn_change_m), (k == int'(S) + 1) ? 32'h1 : 32'h0);
    end
    btn_in = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk("btn0 fall no pulse", 32'(btn_change_m), 32'h0);
    end

    // Simultaneous rise of both buttons, then fall
    btn_in = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      chk($sformatf("btn both edge %0d", k), 32'(btn_change_m), (k == int'(S) + 1) ? 32'h3 : 32'h0);
    end
    btn_in = 2'b00;
    repeat (5) edge1();

    // Mid-operation reset with a button pulse in flight
    Z_in = 4'hC; cap_en = 1'b1;
    edge1();
    cap_en = 1'b0;
    chk("midrst pre valid", 32'(valid_m), 32'h1);
    btn_in = 2'b01;
    edge1();
    rst = 1'b0; btn_in = 2'b00;
    edge1();
    rst = 1'b1;
    chk("midrst valid_m", 32'(valid_m), 32'h0);
    chk("midrst overrun", 32'(overrun), 32'h0);
    chk("midrst btn_change_m", 32'(btn_change_m), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk("midrst pulse suppressed", 32'(btn_change_m), 32'h0);
    end

    // Table sweep checked by the model, with buttons toggling alongside
    for (int i = 0; i < 10; i++) begin
      cap_en = tbl[i].cap; ready_in = tbl[i].rdy;
      Z_in = tbl[i].z; Y_in = tbl[i].y; mode_in = tbl[i].m;
      btn_in = BTN_W'(i >> 1);
      edge1();
    end
    cap_en = 1'b0; ready_in = 1'b0; btn_in = 2'b00;
    repeat (6) edge1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/registro_carga_sync.md
Name: registro_carga_sync

Overview:
- Parametrised successor to the lab input-capture register.
- Captures the operands Z and Y and the mode field into a holding register on a capture strobe, and presents them downstream with a valid/ready handshake.
- Flags an overrun if a new capture arrives while the held data is still unconsumed.
- Synchronises the raw asynchronous push-button inputs and emits one-cycle rising-edge pulses.
- Sits between the board switches/buttons and the ALU datapath.

Parameters:
- N, 4, operand width of Z and Y.
- MODE_W, 2, width of the mode field.
- BTN_W, 2, number of push-button inputs.
- SYNC_STAGES, 2, flip-flops per button synchroniser chain (legal range 2..4).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- Z_in  in  N  operand Z from switches.
- Y_in  in  N  operand Y from switches.
- mode_in  in  MODE_W  operation mode select.
- cap_en  in  1  capture request, sampled every clock (synchronous to clk).
- btn_in  in  BTN_W  raw asynchronous push-buttons, active-high.
- ready_in  in  1  downstream accepts the held data this cycle.
- Z_m  out  N  held operand Z.
- Y_m  out  N  held operand Y.
- mode_m  out  MODE_W  held mode.
- valid_m  out  1  held data is valid.
- btn_change_m  out  BTN_W  one-cycle pulse per button rising edge.
- overrun  out  1  sticky flag: a capture was dropped.

Behaviour:
- Reset: rst==0 at a clock edge clears Z_m, Y_m, mode_m, valid_m, btn_change_m, overrun and all synchroniser and edge-history flops to 0. State goes to IDLE. Reset overrides all other inputs. A mid-operation reset discards held data without a handshake.
- All output registers use nonblocking assignment. No combinational path from any input to any output.
- State machine has two states, IDLE (valid_m=0) and FULL (valid_m=1):
  - IDLE & cap_en=1: load Z_in/Y_in/mode_in on this edge; next cycle valid_m=1, state FULL. Capture latency is 1 cycle.
  - IDLE & cap_en=0: hold.
  - FULL & ready_in=1 & cap_en=0: transfer complete; valid_m=0 next cycle, state IDLE. Data registers keep their last value.
  - FULL & ready_in=1 & cap_en=1: back-to-back. Load new data, stay FULL, valid_m stays 1. No overrun.
  - FULL & ready_in=0 & cap_en=1: capture dropped. Held data unchanged, overrun set to 1 next cycle.
  - FULL & ready_in=0 & cap_en=0: hold data and valid_m.
- ready_in in IDLE is ignored.
- overrun clears only on reset.
- Handshake rules:
  - Z_m/Y_m/mode_m must not change while valid_m=1 except on an accepted transfer (ready_in=1).
  - A transfer occurs on any edge where valid_m=1 and ready_in=1.
- Buttons:
  - Each btn_in bit passes through a SYNC_STAGES-flop chain, then one history flop.
  - btn_change_m[i]=1 for exactly one cycle when synchronised bit i goes 0 to 1; the pulse is registered.
  - Latency from the btn_in rising edge (meeting setup) to the pulse is SYNC_STAGES+1 cycles.
  - Held-high buttons produce no further pulses. Falling edges produce no pulse.
  - Button bits are independent; simultaneous edges pulse simultaneously.
  - The button path is independent of the capture handshake.
- Widths: all fields are copied bit-exact; no arithmetic, no sign extension.

Test Plan:
- Reset: drive all inputs nonzero, rst=0 for 2 cycles -> all outputs 0, valid_m=0. Release rst; the first edge with rst=1 keeps outputs 0 when cap_en=0.
- Basic capture, N=4: Z_in=4'hA, Y_in=4'h5, mode_in=2'b10, one-cycle cap_en -> next cycle Z_m=A, Y_m=5, mode_m=2, valid_m=1. Pulse ready_in=1 -> valid_m=0 next cycle, Z_m stays A.
- Overrun: capture Z=3, ready_in=0, then cap_en with Z_in=7 -> Z_m stays 3, overrun=1 and stays 1 after a later transfer until reset.
- Back-to-back: valid_m=1 with Z_m=3; ready_in=1 and cap_en=1 with Z_in=9 same cycle -> Z_m=9, valid_m=1, overrun=0.
- Button edge, SYNC_STAGES=2: btn_in[0] rises and stays high 10 cycles -> btn_change_m[0]=1 for exactly 1 cycle, 3 cycles after the rise. btn_in[1] rising together gives a simultaneous pulse; a falling edge gives no pulse.
- Reset mid-operation: valid_m=1, then rst=0 for one cycle -> valid_m=0, overrun=0, btn_change_m=0. A button pulse in flight is suppressed.
